// File: rtl/spi_flash_reader.sv
// Read-only SPI flash sequencer: wakes the flash from deep power-down, then
// streams bytes for 0x03 READ requests (mode 0, single-bit IO).
module spi_flash_reader #(
  parameter int CLK_DIV     = 2,
  parameter int WAKE_CYCLES = 1200,
  parameter int CS_HIGH     = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_len,
  output logic        data_valid,
  output logic [7:0]  data,
  input  logic        data_ready,
  output logic        done,
  output logic        busy,
  output logic        FLASH_SCK,
  output logic        FLASH_SSB,
  output logic        FLASH_IO0,
  input  logic        FLASH_IO1
);

  typedef enum logic [3:0] {
    WAKE_CMD, WAKE_CS, WAKE_WAIT, IDLE, CMD, ADDR, DATA, HOLD, DESEL
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] WAKE_LAST = 16'(WAKE_CYCLES - 1);
  localparam logic [15:0] CS_LAST   = 16'(CS_HIGH - 1);

  state_t      state, state_n;
  logic [15:0] div_cnt, wait_cnt, remaining;
  logic [4:0]  bit_cnt, bit_last;
  logic [31:0] tx;
  logic [7:0]  rx;
  logic        tick, shifting, wake_start, byte_end;
  logic        do_rise, do_fall, last_fall, accept, hold_ack, last_byte;

  always_comb begin
    tick       = (div_cnt == DIV_LAST);
    wake_start = (state == WAKE_CMD) && FLASH_SSB;
    shifting   = ((state == WAKE_CMD) && !FLASH_SSB) || (state == CMD) ||
                 (state == ADDR) || (state == DATA);
    bit_last   = (state == ADDR) ? 5'd23 : 5'd7;
    // WAKE_CMD and DATA finish one full low half-period after the last fall,
    // which keeps SSB rise / HOLD entry CLK_DIV clear of the final SCK edge.
    byte_end   = shifting && tick && !FLASH_SCK && (bit_cnt == 5'd8) &&
                 ((state == WAKE_CMD) || (state == DATA));
    accept     = (state == IDLE) && req_valid && req_ready;
    hold_ack   = (state == HOLD) && data_ready;
    last_byte  = (remaining == 16'd1);
    do_fall    = shifting && tick && FLASH_SCK;
    last_fall  = do_fall && (bit_cnt == bit_last);
    do_rise    = (shifting && tick && !FLASH_SCK && !byte_end) ||
                 (hold_ack && !last_byte);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAKE_CMD:  if (byte_end) state_n = WAKE_CS;
      WAKE_CS:   state_n = WAKE_WAIT;
      WAKE_WAIT: if (wait_cnt == WAKE_LAST) state_n = IDLE;
      IDLE:      if (accept && (req_len != '0)) state_n = CMD;
      CMD:       if (last_fall) state_n = ADDR;
      ADDR:      if (last_fall) state_n = DATA;
      DATA:      if (byte_end) state_n = HOLD;
      HOLD:      if (hold_ack) state_n = last_byte ? DESEL : DATA;
      DESEL:     if (wait_cnt == CS_LAST) state_n = IDLE;
      default:   state_n = WAKE_CMD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= WAKE_CMD;
      req_ready  <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
      FLASH_SCK  <= 1'b0;
      FLASH_SSB  <= 1'b1;
      FLASH_IO0  <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      tx         <= {8'hAB, 24'h000000};
      rx         <= '0;
      remaining  <= '0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      done      <= (accept && (req_len == '0)) || (hold_ack && last_byte);
      div_cnt   <= (shifting && !tick) ? div_cnt + 16'd1 : '0;
      wait_cnt  <= ((state == WAKE_CS) || (state == WAKE_WAIT) || (state == DESEL)) ?
                   wait_cnt + 16'd1 : '0;

      if (state_n != state) bit_cnt <= '0;
      else if (do_fall)     bit_cnt <= bit_cnt + 5'd1;

      if (do_rise) begin
        FLASH_SCK <= 1'b1;
        rx        <= {rx[6:0], FLASH_IO1};
      end else if (do_fall) begin
        FLASH_SCK <= 1'b0;
      end

      if (wake_start) begin
        FLASH_SSB <= 1'b0;
        FLASH_IO0 <= tx[31];
      end else if (accept && (req_len != '0)) begin
        FLASH_SSB <= 1'b0;
        FLASH_IO0 <= 1'b0;
        tx        <= {8'h03, req_addr};
        remaining <= req_len;
      end else if (do_fall) begin
        tx        <= {tx[30:0], 1'b0};
        FLASH_IO0 <= ((state == DATA) || ((state == ADDR) && last_fall)) ? 1'b0 : tx[30];
      end

      if (byte_end && (state == WAKE_CMD)) FLASH_SSB <= 1'b1;

      if (byte_end && (state == DATA)) begin
        data_valid <= 1'b1;
        data       <= rx;
      end else if (hold_ack) begin
        data_valid <= 1'b0;
      end

      if (hold_ack) begin
        if (last_byte) FLASH_SSB <= 1'b1;
        else           remaining <= remaining - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: SPI flash model plus table-driven read vectors
// and directed wake, stall, zero-length, back-to-back and reset sequences.
module tb_spi_flash_reader;

  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        data_valid;
  logic [7:0]  data;
  logic        data_ready = 1'b1;
  logic        done;
  logic        busy;
  logic        flash_sck, flash_ssb, flash_io0;
  logic        flash_io1 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] flash_word = '0;
  int          rise_cnt = 0;
  int          sck_total = 0;
  int          sck_while_high = 0;
  int          data_ones = 0;
  int          ssb_falls = 0;
  int          done_cnt = 0;
  logic [31:0] hdr = '0;
  logic        sck_prev = 1'b0;
  logic        ssb_prev = 1'b1;

  spi_flash_reader #(.CLK_DIV(2), .WAKE_CYCLES(50), .CS_HIGH(8)) dut (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .data_valid(data_valid), .data(data), .data_ready(data_ready),
    .done(done), .busy(busy),
    .FLASH_SCK(flash_sck), .FLASH_SSB(flash_ssb),
    .FLASH_IO0(flash_io0), .FLASH_IO1(flash_io1)
  );

  always #(PERIOD / 2) clk = ~clk;

  // Flash model and bus monitor: MOSI capture on SCK rise, MISO update on SCK fall.
  always @(negedge clk) begin
    if (!flash_ssb && ssb_prev) begin
      rise_cnt = 0;
      data_ones = 0;
      hdr = '0;
      ssb_falls++;
    end
    if (flash_sck && !sck_prev) begin
      sck_total++;
      if (flash_ssb) sck_while_high++;
      if (rise_cnt >= 32 && flash_io0) data_ones++;
      if (rise_cnt < 32) hdr = {hdr[30:0], flash_io0};
      rise_cnt++;
    end
    if (!flash_sck && sck_prev)
      flash_io1 = (rise_cnt >= 32 && rise_cnt < 64) ? flash_word[63 - rise_cnt] : 1'b0;
    if (done) done_cnt++;
    sck_prev = flash_sck;
    ssb_prev = flash_ssb;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'(1));
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!data_valid && n < 400) begin @(negedge clk); n++; end
    ok = data_valid;
    if (!ok) chk("valid_timeout", 64'(data_valid), 64'(1));
  endtask

  task automatic wake_check();
    int n = 0;
    while (flash_ssb && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!flash_ssb && n < 500) begin @(negedge clk); n++; end
    chk("wake_ssb_high", 64'(flash_ssb), 64'(1));
    chk("wake_cmd_byte", 64'(hdr), 64'h0000_00AB);
    chk("wake_sck_rises", 64'(rise_cnt), 64'(8));
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("wake_wait_cycles", 64'(n), 64'(50));
    chk("wake_busy_low", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    logic [31:0] flash;
    int          stall_at;
    int          stall_len;
    logic [31:0] exp_hdr;
    logic [31:0] exp_data;
    int          exp_rises;
  } vec_t;

  task automatic run_read(input vec_t v);
    int dn0, tot0, n;
    bit ok;
    logic [7:0] exp_b;
    wait_ready();
    flash_word = v.flash;
    dn0 = done_cnt;
    tot0 = sck_total;
    @(negedge clk);
    req_valid = 1'b1; req_addr = v.addr; req_len = v.len;
    @(negedge clk);
    req_valid = 1'b0;
    chk("accept_state", 64'({req_ready, busy, flash_ssb}), 64'(3'b010));
    for (int b = 0; b < int'(v.len); b++) begin
      exp_b = 8'(v.exp_data >> (24 - 8 * b));
      wait_valid(ok);
      if (!ok) break;
      if (b == v.stall_at) begin
        data_ready = 1'b0;
        for (int c = 0; c < v.stall_len; c++) begin
          @(negedge clk);
          chk("stall_hold", 64'({flash_sck, flash_ssb, data_valid, data}), 64'({3'b001, exp_b}));
        end
        data_ready = 1'b1;
      end
      chk("data_byte", 64'(data), 64'(exp_b));
      @(negedge clk);
    end
    chk("done_with_ssb_rise", 64'({done, flash_ssb}), 64'(2'b11));
    n = 0;
    ok = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk); n++;
      if (!flash_ssb) ok = 1'b0;
    end
    chk("cs_high_time", 64'(n >= 8 && ok), 64'(1));
    chk("mosi_header", 64'(hdr), 64'(v.exp_hdr));
    chk("mosi_data_zero", 64'(data_ones), 64'(0));
    chk("sck_rises_txn", 64'(rise_cnt), 64'(v.exp_rises));
    chk("sck_rises_total", 64'(sck_total - tot0), 64'(v.exp_rises));
    chk("done_pulses", 64'(done_cnt - dn0), 64'(1));
  endtask

  vec_t vecs[5];

  initial begin
    int n, acc, dn, f0, d0;
    bit ok;
    time t_rise, t_acc2;
    logic pssb;

    vecs[0] = '{24'h100000, 16'd4, 32'hA55A01FE, -1, 0,  32'h03100000, 32'hA55A01FE, 64};
    vecs[1] = '{24'h100000, 16'd4, 32'hA55A01FE,  1, 20, 32'h03100000, 32'hA55A01FE, 64};
    vecs[2] = '{24'hABCDEF, 16'd2, 32'h3CC30000, -1, 0,  32'h03ABCDEF, 32'h3CC30000, 48};
    vecs[3] = '{24'h000001, 16'd1, 32'h80000000, -1, 0,  32'h03000001, 32'h80000000, 40};
    vecs[4] = '{24'hFFFFFF, 16'd3, 32'h0FF06900,  0, 5,  32'h03FFFFFF, 32'h0FF06900, 56};

    repeat (3) @(negedge clk);
    chk("reset_values",
        64'({flash_ssb, flash_sck, flash_io0, req_ready, data_valid, data, done, busy}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}));
    rst_n = 1'b1;
    wake_check();

    for (int i = 0; i < 5; i++) run_read(vecs[i]);

    // Zero-length request: done the cycle after accept, chip select untouched.
    wait_ready();
    f0 = ssb_falls; d0 = done_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 24'h123456; req_len = 16'd0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("len0_done", 64'({done, req_ready, flash_ssb, busy}), 64'(4'b1110));
    @(negedge clk);
    chk("len0_done_single", 64'(done), 64'(0));
    repeat (10) @(negedge clk);
    chk("len0_no_ssb_fall", 64'(ssb_falls - f0), 64'(0));
    chk("len0_done_count", 64'(done_cnt - d0), 64'(1));

    // Back-to-back single-byte requests with req_valid held high.
    wait_ready();
    flash_word = 32'h96000000;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 24'h000200; req_len = 16'd1;
    acc = 0; dn = 0; t_rise = 0; t_acc2 = 0; pssb = flash_ssb;
    for (int i = 0; i < 600 && dn < 2; i++) begin
      if (i > 0) @(negedge clk);
      if (acc == 2) req_valid = 1'b0;
      if (flash_ssb && !pssb && acc == 1) t_rise = $time;
      pssb = flash_ssb;
      if (done) dn++;
      if (data_valid && data_ready) chk("b2b_data", 64'(data), 64'h96);
      if (req_valid && req_ready) begin
        acc++;
        if (acc == 2) t_acc2 = $time;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 64'(acc), 64'(2));
    chk("b2b_done_pulses", 64'(dn), 64'(2));
    chk("b2b_cs_gap", 64'(int'((t_acc2 - t_rise) / PERIOD) + 1 >= 8), 64'(1));

    // Reset during the second data byte, then wake again and read.
    wait_ready();
    flash_word = 32'hA55A01FE;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 24'h100000; req_len = 16'd4;
    @(negedge clk);
    req_valid = 1'b0;
    wait_valid(ok);
    chk("rst_first_byte", 64'(data), 64'hA5);
    @(negedge clk);
    n = 0;
    while (rise_cnt < 43 && n < 200) begin @(negedge clk); n++; end
    chk("rst_mid_byte2", 64'(rise_cnt >= 43 && !flash_ssb), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_outputs", 64'({flash_ssb, data_valid, flash_sck, busy, req_ready}), 64'(5'b10010));
    wake_check();
    run_read(vecs[0]);
    run_read(vecs[2]);

    chk("no_sck_while_ssb_high", 64'(sck_while_high), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(PERIOD * 40000);
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Read-only sequencer for the iCEBreaker SPI configuration flash. Wakes the flash from deep power-down after reset, then serves byte-stream read requests (standard 0x03 READ, SPI mode 0, single-bit IO) from the PipelineC fabric. Runs in the PLL clock domain. Drives FLASH_SCK/FLASH_SSB/FLASH_IO0 and samples FLASH_IO1; FLASH_IO2/IO3 are held high by the top level (WP#/HOLD# inactive).

## Interface
- CLK_DIV, 2: SCK half-period in CLK cycles (≥1); SCK period = 2*CLK_DIV.
- WAKE_CYCLES, 1200: CLK cycles to wait after the 0xAB wake command (tRES1 ≥ 3 µs with margin).
- CS_HIGH, 8: minimum CLK cycles FLASH_SSB stays high between transactions.
- CLK  in  1  system clock (pll_clk).
- RST_N  in  1  synchronous, active-low reset.
- req_valid  in  1  read request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  24  start byte address.
- req_len  in  16  byte count; 0 is legal.
- data_valid  out  1  data byte available.
- data  out  8  received byte.
- data_ready  in  1  consumer accepts byte when data_valid && data_ready.
- done  out  1  one-cycle pulse when a request completes.
- busy  out  1  high in every state except IDLE.
- FLASH_SCK  out  1  SPI clock, idles low.
- FLASH_SSB  out  1  chip select, active low.
- FLASH_IO0  out  1  MOSI.
- FLASH_IO1  in  1  MISO.

## Operation
- States: WAKE_CMD → WAKE_CS → WAKE_WAIT → IDLE → CMD → ADDR → DATA ⇄ HOLD → DESEL → IDLE.
- WAKE_CMD: SSB low, shift 0xAB MSB first. WAKE_CS: SSB high. WAKE_WAIT: count WAKE_CYCLES, then IDLE.
- IDLE: req_ready=1. On accept, latch addr and len. If len==0, pulse done next cycle, stay in IDLE, SSB untouched. Otherwise, SSB low and enter CMD.
- CMD: shift 0x03 (8 bits). ADDR: shift addr[23:0] MSB first (24 bits). DATA: shift IO0=0 and sample IO1 into the byte, MSB first.
- After the 8th bit of a byte is sampled, enter HOLD: data_valid=1, data=byte, SCK held low, SSB held low (clock pause is legal in mode 0).
- HOLD, on data_valid && data_ready:
  - If remaining > 0, decrement remaining, go to DATA.
  - If this was the last byte, enter DESEL: SSB high, done pulses on entry.
- DESEL: hold SSB high for CS_HIGH cycles, then IDLE.
- Byte counter is 16-bit down-counter loaded with req_len; no wrap. Flash internally wraps at end of array; the block does not check the address.
- req_ready=0 in every state but IDLE; requests are never queued.
- Reset at any time, including mid-transfer: next edge forces the reset values and restarts at WAKE_CMD. Any partial byte is discarded.

## Timing
- Reset values: FLASH_SSB=1, FLASH_SCK=0, FLASH_IO0=0, req_ready=0, data_valid=0, data=0, done=0, busy=1.
- All outputs are registered; no combinational input→output path.
- Mode 0 bit timing:
  - IO0 updates with SCK falling, or with SSB falling for bit 0.
  - SCK is high for CLK_DIV cycles and low for CLK_DIV cycles.
  - IO1 is sampled on the CLK edge that drives SCK high.
- SSB falls ≥CLK_DIV cycles before the first SCK rise. SSB rises ≥CLK_DIV cycles after the last SCK fall.
- Latency:
  - Accept to first SCK rise: CLK_DIV+1 cycles.
  - Request to first data_valid: 40*2*CLK_DIV (approx.) cycles.
- Byte throughput without backpressure: one byte per 16*CLK_DIV+1 cycles.
- done pulses exactly once per accepted request, coincident with SSB rising (or the cycle after accept when len==0).

## Test plan
- Reset release, CLK_DIV=2, WAKE_CYCLES=50 → IO0 carries 0xAB over 8 SCK pulses; SSB high; req_ready rises exactly 50 cycles after SSB rises; busy falls with it.
- Read addr 0x100000, len 4, flash model returns A5 5A 01 FE → MOSI sees 03 10 00 00; exactly 64 SCK rises in total; data emits A5, 5A, 01, FE in order; one done pulse; SSB high ≥8 cycles afterward.
- Same read with data_ready low for 20 cycles on byte 2 → SCK stays low and SSB stays low throughout; data holds 5A; the stream resumes correctly and the byte count is unchanged.
- len=0 request → done one cycle after accept; SSB never falls; req_ready stays high.
- RST_N low for 1 cycle during the 2nd data byte → next cycle SSB=1, data_valid=0, SCK=0; the wake sequence reruns; a subsequent read returns correct data.
- req_valid held high with two back-to-back len=1 requests → second accept occurs ≥CS_HIGH cycles after SSB rises; two done pulses; no SCK activity while SSB is high.
